// File: rtl/cve2_xif_coproc_pkg.sv
// Shared types and constants for the XIF coprocessor-side controller.
package cve2_xif_coproc_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_OPS  = 3'd1,
    S_EXEC_REQ  = 3'd2,
    S_EXEC_WAIT = 3'd3,
    S_RESULT    = 3'd4
  } coproc_state_e;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'h0B;
  localparam logic [1:0] REG_READ_BOTH  = 2'b11;

endpackage

// File: rtl/cve2_xif_coproc_ctrl.sv
// XIF coprocessor endpoint: decodes custom-0 offloads, gathers operands and commit,
// drives a local execution unit and returns the result. One instruction in flight.
//
// state       | meaning
// S_IDLE      | ready for a new issue; stray operand transfers are swallowed
// S_WAIT_OPS  | accepted, waiting for both operands and a non-kill commit
// S_EXEC_REQ  | request presented to the execution unit
// S_EXEC_WAIT | waiting for the execution unit response strobe
// S_RESULT    | result presented to the host core
module cve2_xif_coproc_ctrl
  import cve2_xif_coproc_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH     = 4,
  parameter int unsigned X_HARTID_WIDTH = 1,
  parameter int unsigned X_RFR_WIDTH    = 32,
  parameter logic [6:0]  OPCODE         = OPCODE_CUSTOM0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      issue_valid_i,
  output logic                      issue_ready_o,
  input  logic [31:0]               issue_instr_i,
  input  logic [X_ID_WIDTH-1:0]     issue_id_i,
  input  logic [X_HARTID_WIDTH-1:0] issue_hartid_i,
  output logic                      issue_accept_o,
  output logic                      issue_writeback_o,
  output logic [1:0]                issue_register_read_o,
  output logic                      issue_ecswrite_o,
  input  logic                      commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]     commit_id_i,
  input  logic [X_HARTID_WIDTH-1:0] commit_hartid_i,
  input  logic                      commit_kill_i,
  input  logic                      register_valid_i,
  output logic                      register_ready_o,
  input  logic [X_ID_WIDTH-1:0]     register_id_i,
  input  logic [X_HARTID_WIDTH-1:0] register_hartid_i,
  input  logic [X_RFR_WIDTH-1:0]    register_rs0_i,
  input  logic [X_RFR_WIDTH-1:0]    register_rs1_i,
  input  logic [1:0]                register_rs_valid_i,
  output logic                      result_valid_o,
  input  logic                      result_ready_i,
  output logic [X_ID_WIDTH-1:0]     result_id_o,
  output logic [X_HARTID_WIDTH-1:0] result_hartid_o,
  output logic [X_RFR_WIDTH-1:0]    result_data_o,
  output logic [4:0]                result_rd_o,
  output logic                      result_we_o,
  output logic                      result_exc_o,
  output logic                      result_err_o,
  output logic                      result_dbg_o,
  output logic [5:0]                result_exccode_o,
  output logic                      exu_req_valid_o,
  input  logic                      exu_req_ready_i,
  output logic [31:0]               exu_instr_o,
  output logic [X_RFR_WIDTH-1:0]    exu_op_a_o,
  output logic [X_RFR_WIDTH-1:0]    exu_op_b_o,
  input  logic                      exu_resp_valid_i,
  input  logic [X_RFR_WIDTH-1:0]    exu_resp_data_i
);

  coproc_state_e              r_state;
  coproc_state_e              w_state_nxt;
  logic [31:0]                r_instr;
  logic [X_ID_WIDTH-1:0]      r_id;
  logic [X_HARTID_WIDTH-1:0]  r_hartid;
  logic                       r_reg_got;
  logic                       r_commit_got;
  logic [X_RFR_WIDTH-1:0]     r_op_a;
  logic [X_RFR_WIDTH-1:0]     r_op_b;
  logic [X_RFR_WIDTH-1:0]     r_data;

  logic w_idle, w_wait_ops, w_accept, w_issue_hs, w_issue_acc;
  logic w_reg_ready, w_reg_take, w_commit_match, w_commit_vld, w_kill, w_commit_ok;

  assign w_idle      = (r_state == S_IDLE);
  assign w_wait_ops  = (r_state == S_WAIT_OPS);
  assign w_accept    = (issue_instr_i[6:0] == OPCODE);
  assign w_issue_hs  = issue_valid_i & w_idle;
  assign w_issue_acc = w_issue_hs & w_accept;
  assign w_reg_ready = w_idle | (w_wait_ops & ~r_reg_got);

  // Operand transfers that do not match (or arrive in IDLE) are handshaken and dropped.
  assign w_reg_take = register_valid_i & w_reg_ready & w_wait_ops
                    & (register_id_i == r_id) & (register_hartid_i == r_hartid)
                    & (register_rs_valid_i == REG_READ_BOTH);

  // A commit may ride along with its own issue handshake, so match against the live issue id then.
  assign w_commit_match = w_idle ? ((commit_id_i == issue_id_i) & (commit_hartid_i == issue_hartid_i))
                                 : ((commit_id_i == r_id) & (commit_hartid_i == r_hartid));
  assign w_commit_vld   = commit_valid_i & (w_issue_acc | w_wait_ops) & w_commit_match;
  assign w_kill         = w_commit_vld & commit_kill_i;
  assign w_commit_ok    = w_commit_vld & ~commit_kill_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_issue_acc && !w_kill) w_state_nxt = S_WAIT_OPS;
      S_WAIT_OPS: begin
        if (w_kill) w_state_nxt = S_IDLE;
        else if ((r_reg_got | w_reg_take) & (r_commit_got | w_commit_ok)) w_state_nxt = S_EXEC_REQ;
      end
      S_EXEC_REQ:  if (exu_req_ready_i) w_state_nxt = S_EXEC_WAIT;
      S_EXEC_WAIT: if (exu_resp_valid_i) w_state_nxt = S_RESULT;
      S_RESULT:    if (result_ready_i) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_instr      <= '0;
      r_id         <= '0;
      r_hartid     <= '0;
      r_reg_got    <= 1'b0;
      r_commit_got <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_data       <= '0;
    end else begin
      if (w_issue_acc) begin
        r_instr      <= issue_instr_i;
        r_id         <= issue_id_i;
        r_hartid     <= issue_hartid_i;
        r_reg_got    <= 1'b0;
        r_commit_got <= w_commit_ok;
      end else if (w_wait_ops) begin
        if (w_kill) begin
          r_reg_got    <= 1'b0;
          r_commit_got <= 1'b0;
          r_op_a       <= '0;
          r_op_b       <= '0;
        end else begin
          if (w_reg_take) begin
            r_reg_got <= 1'b1;
            r_op_a    <= register_rs0_i;
            r_op_b    <= register_rs1_i;
          end
          if (w_commit_ok) r_commit_got <= 1'b1;
        end
      end
      if ((r_state == S_EXEC_WAIT) && exu_resp_valid_i) r_data <= exu_resp_data_i;
    end
  end

  always_comb begin
    issue_ready_o         = w_idle;
    issue_accept_o        = w_issue_hs & w_accept;
    issue_writeback_o     = w_issue_hs & w_accept & (issue_instr_i[11:7] != 5'd0);
    issue_register_read_o = (w_issue_hs & w_accept) ? REG_READ_BOTH : 2'b00;
    issue_ecswrite_o      = 1'b0;
    register_ready_o      = w_reg_ready;
    exu_req_valid_o       = (r_state == S_EXEC_REQ);
    exu_instr_o           = r_instr;
    exu_op_a_o            = r_op_a;
    exu_op_b_o            = r_op_b;
    result_valid_o        = (r_state == S_RESULT);
    result_id_o           = r_id;
    result_hartid_o       = r_hartid;
    result_data_o         = r_data;
    result_rd_o           = r_instr[11:7];
    result_we_o           = (r_instr[11:7] != 5'd0);
    result_exc_o          = 1'b0;
    result_err_o          = 1'b0;
    result_dbg_o          = 1'b0;
    result_exccode_o      = 6'd0;
  end

endmodule

// File: tb/tb_cve2_xif_coproc_ctrl.sv
// Scoreboard bench for cve2_xif_coproc_ctrl: driver pushes expected EXU requests and
// results, independent monitors pop and compare; the EXU model returns op_a + op_b.
module tb_cve2_xif_coproc_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        issue_valid_i, issue_ready_o;
  logic [31:0] issue_instr_i;
  logic [3:0]  issue_id_i;
  logic        issue_hartid_i;
  logic        issue_accept_o, issue_writeback_o, issue_ecswrite_o;
  logic [1:0]  issue_register_read_o;
  logic        commit_valid_i, commit_hartid_i, commit_kill_i;
  logic [3:0]  commit_id_i;
  logic        register_valid_i, register_ready_o, register_hartid_i;
  logic [3:0]  register_id_i;
  logic [31:0] register_rs0_i, register_rs1_i;
  logic [1:0]  register_rs_valid_i;
  logic        result_valid_o, result_ready_i, result_hartid_o, result_we_o;
  logic [3:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic        result_exc_o, result_err_o, result_dbg_o;
  logic [5:0]  result_exccode_o;
  logic        exu_req_valid_o, exu_req_ready_i, exu_resp_valid_i;
  logic [31:0] exu_instr_o, exu_op_a_o, exu_op_b_o, exu_resp_data_i;

  cve2_xif_coproc_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_instr_i(issue_instr_i),
    .issue_id_i(issue_id_i), .issue_hartid_i(issue_hartid_i), .issue_accept_o(issue_accept_o),
    .issue_writeback_o(issue_writeback_o), .issue_register_read_o(issue_register_read_o),
    .issue_ecswrite_o(issue_ecswrite_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_hartid_i(commit_hartid_i),
    .commit_kill_i(commit_kill_i),
    .register_valid_i(register_valid_i), .register_ready_o(register_ready_o),
    .register_id_i(register_id_i), .register_hartid_i(register_hartid_i),
    .register_rs0_i(register_rs0_i), .register_rs1_i(register_rs1_i),
    .register_rs_valid_i(register_rs_valid_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_id_o(result_id_o),
    .result_hartid_o(result_hartid_o), .result_data_o(result_data_o), .result_rd_o(result_rd_o),
    .result_we_o(result_we_o), .result_exc_o(result_exc_o), .result_err_o(result_err_o),
    .result_dbg_o(result_dbg_o), .result_exccode_o(result_exccode_o),
    .exu_req_valid_o(exu_req_valid_o), .exu_req_ready_i(exu_req_ready_i),
    .exu_instr_o(exu_instr_o), .exu_op_a_o(exu_op_a_o), .exu_op_b_o(exu_op_b_o),
    .exu_resp_valid_i(exu_resp_valid_i), .exu_resp_data_i(exu_resp_data_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [31:0] instr; logic [31:0] a; logic [31:0] b; } req_t;
  typedef struct packed { logic [3:0] id; logic hart; logic [31:0] data; logic [4:0] rd; logic we; } res_t;

  req_t exp_req[$];
  res_t exp_res[$];
  int   checks = 0;
  int   errors = 0;
  int   res_done = 0;
  int   n_exp = 0;
  bit   hold_exu_ready = 1'b0;
  bit   hold_res_ready = 1'b0;
  bit   exu_no_resp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic clr_in();
    issue_valid_i = 0; commit_valid_i = 0; commit_kill_i = 0;
    register_valid_i = 0; register_rs_valid_i = 2'b00;
  endtask

  task automatic idle_chk();
    @(negedge clk_i);
    chk("no_early_req", exu_req_valid_o, 0);
    step();
  endtask

  task automatic do_issue(input logic [31:0] instr, input logic [3:0] id, input logic hart,
                          input bit cmt, input bit kill);
    bit acc;
    acc = (instr[6:0] == 7'h0B);
    issue_valid_i = 1; issue_instr_i = instr; issue_id_i = id; issue_hartid_i = hart;
    if (cmt) begin
      commit_valid_i = 1; commit_id_i = id; commit_hartid_i = hart; commit_kill_i = kill;
    end
    @(negedge clk_i);
    chk("issue_ready", issue_ready_o, 1);
    chk("issue_accept", issue_accept_o, acc);
    chk("issue_writeback", issue_writeback_o, acc && (instr[11:7] != 5'd0));
    chk("issue_register_read", issue_register_read_o, acc ? 2'b11 : 2'b00);
    chk("issue_ecswrite", issue_ecswrite_o, 0);
    step(); clr_in();
  endtask

  task automatic do_reg(input logic [3:0] id, input logic hart, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] rsv, input bit cmt);
    register_valid_i = 1; register_id_i = id; register_hartid_i = hart;
    register_rs0_i = a; register_rs1_i = b; register_rs_valid_i = rsv;
    if (cmt) begin
      commit_valid_i = 1; commit_id_i = id; commit_hartid_i = hart; commit_kill_i = 0;
    end
    @(negedge clk_i);
    chk("register_ready", register_ready_o, 1);
    step(); clr_in();
  endtask

  task automatic do_commit(input logic [3:0] id, input logic hart, input bit kill);
    commit_valid_i = 1; commit_id_i = id; commit_hartid_i = hart; commit_kill_i = kill;
    step(); clr_in();
  endtask

  // order: 0 reg+commit together, 1 commit with issue, 2 commit 3 cycles before reg,
  //        3 reg before commit, 4 wrong-id commit then reg then real commit
  task automatic send_ok(input logic [31:0] instr, input logic [3:0] id, input logic hart,
                         input logic [31:0] a, input logic [31:0] b, input int order);
    res_t r;
    do_issue(instr, id, hart, order == 1, 0);
    exp_req.push_back('{instr: instr, a: a, b: b});
    r.id = id; r.hart = hart; r.data = a + b; r.rd = instr[11:7]; r.we = (instr[11:7] != 5'd0);
    exp_res.push_back(r);
    n_exp++;
    if ($urandom_range(0, 1) == 1) begin do_reg(id + 4'd1, hart, ~a, ~b, 2'b11, 0); idle_chk(); end
    if ($urandom_range(0, 1) == 1) begin do_reg(id, ~hart, ~a, b, 2'b11, 0); idle_chk(); end
    if ($urandom_range(0, 1) == 1) begin do_reg(id, hart, a, ~b, 2'b01, 0); idle_chk(); end
    case (order)
      0: do_reg(id, hart, a, b, 2'b11, 1);
      1: do_reg(id, hart, a, b, 2'b11, 0);
      2: begin do_commit(id, hart, 0); idle_chk(); idle_chk(); do_reg(id, hart, a, b, 2'b11, 0); end
      3: begin do_reg(id, hart, a, b, 2'b11, 0); idle_chk(); idle_chk(); do_commit(id, hart, 0); end
      default: begin
        do_commit(id + 4'd1, hart, 0);
        do_reg(id, hart, a, b, 2'b11, 0);
        idle_chk();
        do_commit(id, hart, 0);
      end
    endcase
    @(negedge clk_i);
    chk("req_latency", exu_req_valid_o, 1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (res_done < n_exp && t < 300) begin @(negedge clk_i); t++; end
    chk("txn_complete", res_done, n_exp);
    step();
  endtask

  task automatic send_reject(input logic [3:0] id, input logic hart);
    logic [31:0] w;
    do begin w = $urandom; end while (w[6:0] == 7'h0B);
    do_issue(w, id, hart, $urandom_range(0, 1) == 1, 0);
    @(negedge clk_i);
    chk("reject_stays_idle", issue_ready_o, 1);
    chk("reject_no_req", exu_req_valid_o, 0);
    step();
  endtask

  task automatic send_kill(input logic [31:0] instr, input logic [3:0] id, input logic hart,
                           input bit at_issue);
    if (at_issue) do_issue(instr, id, hart, 1, 1);
    else begin
      do_issue(instr, id, hart, 0, 0);
      do_commit(id + 4'd1, hart, 1);
      @(negedge clk_i);
      chk("wrong_id_kill_ignored", issue_ready_o, 0);
      step();
      do_commit(id, hart, 1);
    end
    @(negedge clk_i);
    chk("kill_to_idle", issue_ready_o, 1);
    step();
    do_reg(id, hart, $urandom, $urandom, 2'b11, 0);
    repeat (3) begin
      @(negedge clk_i);
      chk("no_req_after_kill", exu_req_valid_o, 0);
    end
    step();
  endtask

  function automatic logic [31:0] rand_ok_instr();
    logic [31:0] w;
    w = $urandom;
    w[6:0] = 7'h0B;
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin : exu_model
    int   resp_delay;
    int   lat_stage;
    bit   stall;
    req_t held;
    req_t e;
    logic [31:0] resp_val;
    resp_delay = 0; lat_stage = 0; stall = 0; resp_val = '0;
    exu_req_ready_i = 0; exu_resp_valid_i = 0; exu_resp_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        resp_delay = 0; lat_stage = 0; stall = 0;
      end else begin
        if (lat_stage == 1) begin chk("resp_to_result_early", result_valid_o, 0); lat_stage = 2; end
        else if (lat_stage == 2) begin chk("resp_to_result_latency", result_valid_o, 1); lat_stage = 0; end
        if (exu_req_valid_o) begin
          if (stall) chk("exu_req_stable", {exu_instr_o, exu_op_a_o}, {held.instr, held.a});
          if (stall) chk("exu_req_stable_b", exu_op_b_o, held.b);
          if (exu_req_ready_i) begin
            if (exp_req.size() == 0) begin
              checks++; errors++;
              $display("FAIL exu_req: unexpected request instr %08h, none expected", exu_instr_o);
            end else begin
              e = exp_req.pop_front();
              chk("exu_instr", exu_instr_o, e.instr);
              chk("exu_op_a", exu_op_a_o, e.a);
              chk("exu_op_b", exu_op_b_o, e.b);
            end
            resp_val = exu_op_a_o + exu_op_b_o;
            if (!exu_no_resp) resp_delay = $urandom_range(1, 3);
            stall = 0;
          end else begin
            stall = 1;
            held = '{instr: exu_instr_o, a: exu_op_a_o, b: exu_op_b_o};
          end
        end else stall = 0;
      end
      @(posedge clk_i); #1;
      exu_resp_valid_i = 0;
      if (resp_delay > 0) begin
        resp_delay--;
        if (resp_delay == 0) begin
          exu_resp_valid_i = 1; exu_resp_data_i = resp_val; lat_stage = 1;
        end
      end
      exu_req_ready_i = hold_exu_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : result_monitor
    bit   stall;
    res_t held;
    res_t e;
    stall = 0; result_ready_i = 0;
    forever begin
      @(posedge clk_i); #1;
      result_ready_i = hold_res_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
      @(negedge clk_i);
      if (rst_ni && result_valid_o) begin
        if (stall) chk("result_stable",
                       {result_id_o, result_hartid_o, result_data_o, result_rd_o, result_we_o}, held);
        if (result_ready_i) begin
          if (exp_res.size() == 0) begin
            checks++; errors++;
            $display("FAIL result: unexpected result id %0d data %08h", result_id_o, result_data_o);
          end else begin
            e = exp_res.pop_front();
            chk("result_id", result_id_o, e.id);
            chk("result_hartid", result_hartid_o, e.hart);
            chk("result_data", result_data_o, e.data);
            chk("result_rd", result_rd_o, e.rd);
            chk("result_we", result_we_o, e.we);
            chk("result_tied", {result_exc_o, result_err_o, result_dbg_o, result_exccode_o}, 0);
          end
          res_done++;
          stall = 0;
        end else begin
          stall = 1;
          held = '{id: result_id_o, hart: result_hartid_o, data: result_data_o,
                   rd: result_rd_o, we: result_we_o};
        end
      end else stall = 0;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int t;
    rst_ni = 0;
    clr_in();
    issue_instr_i = '0; issue_id_i = '0; issue_hartid_i = 0;
    commit_id_i = '0; commit_hartid_i = 0;
    register_id_i = '0; register_hartid_i = 0; register_rs0_i = '0; register_rs1_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_issue_ready", issue_ready_o, 1);
    chk("rst_register_ready", register_ready_o, 1);
    chk("rst_issue_accept", issue_accept_o, 0);
    chk("rst_exu_req_valid", exu_req_valid_o, 0);
    chk("rst_result_valid", result_valid_o, 0);
    chk("rst_result_fields", {result_data_o, result_we_o, result_rd_o, result_id_o}, 0);
    rst_ni = 1;
    step();

    // directed: accepted op from the worked example, rs0=5 rs1=7 -> 12, rd=10
    send_ok(32'h0020_850B, 4'd3, 1'b0, 32'd5, 32'd7, 0);
    wait_done();
    do_issue(32'h0000_0033, 4'd1, 1'b0, 0, 0);
    @(negedge clk_i);
    chk("reject_stays_idle", issue_ready_o, 1);
    chk("reject_no_req", exu_req_valid_o, 0);
    step();
    send_kill(32'h0020_850B, 4'd5, 1'b0, 0);
    send_kill(rand_ok_instr(), 4'd6, 1'b1, 1);
    send_ok(rand_ok_instr(), 4'd7, 1'b1, $urandom, $urandom, 2);
    wait_done();

    // backpressure on both the execution request and the result
    hold_exu_ready = 1; hold_res_ready = 1;
    send_ok(rand_ok_instr(), 4'd9, 1'b0, $urandom, $urandom, 0);
    repeat (4) begin
      chk("bp_req_held", exu_req_valid_o, 1);
      chk("bp_issue_blocked", issue_ready_o, 0);
      @(negedge clk_i);
    end
    hold_exu_ready = 0;
    t = 0;
    while (!result_valid_o && t < 50) begin @(negedge clk_i); t++; end
    chk("bp_result_seen", result_valid_o, 1);
    repeat (3) begin
      chk("bp_result_held", result_valid_o, 1);
      chk("bp_issue_blocked_res", issue_ready_o, 0);
      @(negedge clk_i);
    end
    hold_res_ready = 0;
    wait_done();

    // reset while waiting on the execution unit
    exu_no_resp = 1;
    send_ok(rand_ok_instr(), 4'd12, 1'b1, $urandom, $urandom, 0);
    t = 0;
    while (exu_req_valid_o && t < 50) begin @(negedge clk_i); t++; end
    chk("reached_exec_wait", exu_req_valid_o, 0);
    rst_ni = 0;
    #1;
    chk("mid_rst_issue_ready", issue_ready_o, 1);
    chk("mid_rst_register_ready", register_ready_o, 1);
    chk("mid_rst_valids", {exu_req_valid_o, result_valid_o}, 0);
    chk("mid_rst_exu_fields", {exu_instr_o, exu_op_a_o, exu_op_b_o}, 0);
    chk("mid_rst_result_fields", {result_data_o, result_id_o, result_rd_o, result_we_o}, 0);
    exp_res.delete();
    n_exp--;
    @(negedge clk_i);
    rst_ni = 1;
    exu_no_resp = 0;
    step();
    send_ok(rand_ok_instr(), 4'd13, 1'b0, $urandom, $urandom, 0);
    wait_done();

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [3:0] id;
      logic hart;
      kind = $urandom_range(0, 9);
      id = 4'($urandom_range(0, 15));
      hart = 1'($urandom_range(0, 1));
      if (kind < 6) begin
        send_ok(rand_ok_instr(), id, hart, $urandom, $urandom, $urandom_range(0, 4));
        wait_done();
      end else if (kind < 8) send_reject(id, hart);
      else send_kill(rand_ok_instr(), id, hart, $urandom_range(0, 1) == 1);
    end

    repeat (5) @(negedge clk_i);
    chk("leftover_req", exp_req.size(), 0);
    chk("leftover_res", exp_res.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cve2_xif_coproc_ctrl.md
Name: cve2_xif_coproc_ctrl

Overview:
Coprocessor-side endpoint of the CORE-V XIF eXtension interface (issue, commit, register, result), the counterpart to the CPU-side modports.
- Decodes offloaded instructions on one custom opcode and accepts or rejects them.
- Collects source operands and the commit decision, then drives a local execution unit over a valid/ready request plus a response strobe.
- Returns the result to the host core.
- Holds one instruction in flight at a time; sits between the cve2 core XIF and a custom functional unit.

Parameters:
X_ID_WIDTH, 4, width of the instruction id field
X_HARTID_WIDTH, 1, width of the hartid field
X_RFR_WIDTH, 32, operand width; also the result data width
OPCODE, 7'h0B, major opcode (instr[6:0]) that is accepted (custom-0)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
issue_valid_i  in  1  issue request valid
issue_ready_o  out  1  issue request ready
issue_instr_i  in  32  offloaded instruction
issue_id_i  in  X_ID_WIDTH  issue id
issue_hartid_i  in  X_HARTID_WIDTH  issue hartid
issue_accept_o  out  1  instruction accepted
issue_writeback_o  out  1  will write rd
issue_register_read_o  out  2  rs1/rs2 required
issue_ecswrite_o  out  1  tied 0
commit_valid_i  in  1  commit valid
commit_id_i  in  X_ID_WIDTH  commit id
commit_hartid_i  in  X_HARTID_WIDTH  commit hartid
commit_kill_i  in  1  kill instruction
register_valid_i  in  1  operand transfer valid
register_ready_o  out  1  operand transfer ready
register_id_i  in  X_ID_WIDTH  operand id
register_hartid_i  in  X_HARTID_WIDTH  operand hartid
register_rs0_i / register_rs1_i  in  X_RFR_WIDTH each  source operands
register_rs_valid_i  in  2  per-operand valid
result_valid_o  out  1  result valid
result_ready_i  in  1  result accepted
result_id_o  out  X_ID_WIDTH  result id
result_hartid_o  out  X_HARTID_WIDTH  result hartid
result_data_o  out  X_RFR_WIDTH  write data
result_rd_o  out  5  destination register
result_we_o  out  1  write enable
result_exc_o / result_err_o / result_dbg_o  out  1 each  tied 0
result_exccode_o  out  6  tied 0
exu_req_valid_o  out  1  execution request valid
exu_req_ready_i  in  1  execution unit ready
exu_instr_o  out  32  latched instruction
exu_op_a_o / exu_op_b_o  out  X_RFR_WIDTH each  latched rs1/rs2
exu_resp_valid_i  in  1  execution result strobe
exu_resp_data_i  in  X_RFR_WIDTH  execution result

Behaviour:
- Interface decision: single clock clk_i; reset rst_ni is asynchronous and active-low. All state is cleared on reset assertion, including mid-operation; no pending transaction survives.
- FSM states: IDLE, WAIT_OPS, EXEC_REQ, EXEC_WAIT, RESULT. Reset state: IDLE.
- Output reset values: all outputs 0 except issue_ready_o=1 and register_ready_o=1, both combinational in IDLE.
- Issue handshake:
  - issue_ready_o = (state==IDLE).
  - Response is combinational in the handshake cycle: accept = (issue_instr_i[6:0]==OPCODE).
  - writeback = accept & (rd!=0); register_read = accept ? 2'b11 : 2'b00.
  - A rejected issue completes the handshake and the FSM stays in IDLE.
  - An accepted issue latches instr, id and hartid, clears the reg_got and commit_got flags, and moves to WAIT_OPS.
- Register handshake:
  - register_ready_o = IDLE | (WAIT_OPS & !reg_got).
  - A transfer whose id/hartid match the latched ones and whose rs_valid==2'b11 latches rs0/rs1 and sets reg_got.
  - A mismatching transfer, or any transfer in IDLE (stale operands of a killed instruction), is consumed and discarded.
  - rs_valid!=2'b11 with a matching id: ready stays high and the data is ignored until both operands are valid.
- Commit:
  - Only considered when the id/hartid match. Valid in WAIT_OPS, and in IDLE in the same cycle as the accepted issue handshake.
  - commit_kill=1: return to IDLE next cycle, discard all latched state.
  - commit_kill=0: set commit_got.
  - Commits in EXEC_REQ, EXEC_WAIT or RESULT are ignored.
- Transitions:
  - WAIT_OPS → EXEC_REQ when reg_got & commit_got, counting flags set in the same cycle. Register and commit arriving in the same cycle are both latched.
  - EXEC_REQ: exu_req_valid_o=1, held stable until exu_req_ready_i, then → EXEC_WAIT.
  - EXEC_WAIT → RESULT on exu_resp_valid_i; data is latched.
  - RESULT: result_valid_o=1 and all result fields held stable until result_ready_i, then → IDLE. result_rd_o = instr[11:7]; result_we_o = (rd!=0).
- Latency: issue at cycle 0, register+commit at cycle 1 → exu_req_valid_o at cycle 2. exu_resp_valid_i at cycle k → result_valid_o at k+1.
- The next issue is accepted no earlier than the cycle after the result handshake.

Decomposition:
- Package cve2_xif_coproc_pkg holds:
  - state enum coproc_state_e;
  - default custom-0 opcode constant;
  - register_read encoding constant 2'b11.
- No sub-module is needed. Decode is a single compare, kept inline.

Test Plan:
- Accepted op: issue instr 32'h0020_850B, id 3 → accept=1, writeback=1, register_read=11. Register rs0=5, rs1=7 plus commit(kill=0) at cycle 1 → exu_req_valid at cycle 2. EXU returns 12 → result id 3, rd=10, data 12, we=1.
- Reject: issue instr 32'h0000_0033 → accept=0, issue_ready stays 1, state IDLE, no exu request.
- Kill: accept id 5, commit kill=1 before register → back to IDLE. A later register transfer for id 5 is consumed (ready=1) with no exu request.
- Ordering: commit arrives 3 cycles before register → exu_req_valid occurs exactly 1 cycle after the register handshake.
- Backpressure: exu_req_ready low 4 cycles, then result_ready low 3 cycles → req/result fields stable, issue_ready=0 throughout.
- Reset mid-EXEC_WAIT: rst_ni low 1 cycle → all outputs return to reset values, and a fresh issue is accepted immediately.
